// File: rtl/rvga_types.sv
`default_nettype none
// ============================================================================
//  Package : rvga_types
//  Shared word type and responder state encoding.
//  Revision: 1.0
// ============================================================================
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } rvga_mem_state_e;

endpackage
`default_nettype wire

// File: rtl/rvga_mem_array.sv
`default_nettype none
// ============================================================================
//  Module  : rvga_mem_array
//  els_p x 32-bit storage, byte-masked synchronous write, asynchronous read.
//  Revision: 1.0
// ============================================================================
module rvga_mem_array
    import rvga_types::*;
#(
    parameter int els_p  = 1024,
    parameter int ADDR_W = $clog2(els_p)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  rvga_word          wdata_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output rvga_word          rdata_o
);

    rvga_word mem_q [els_p];

    // Contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/rvga_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module  : rvga_mem_responder
//  Fixed-latency single-outstanding word memory responder.
//  Optional byte-masked writes when RVGA_MEM_BYTE_EN is defined.
//  Revision: 1.0
// ============================================================================
module rvga_mem_responder
    import rvga_types::*;
#(
    parameter int els_p     = 1024,
    parameter int latency_p = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       r_v_i,
    input  logic       w_v_i,
    input  rvga_word   addr_i,
    input  rvga_word   data_i,
`ifdef RVGA_MEM_BYTE_EN
    input  logic [3:0] be_i,
`endif
    output rvga_word   data_o,
    output logic       resp_v_o,
    output logic       err_o
);

    localparam int ADDR_W = $clog2(els_p);
    localparam int CNT_W  = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(latency_p - 1);

    rvga_mem_state_e   state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] idx_q;
    rvga_word          wdata_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic              oor_q;
    logic              resp_v_q;
    rvga_word          data_q;
    logic              err_q;

    logic [3:0]        req_be;
    logic              req_oor;
    logic              cur_wr;
    logic              cur_oor;
    logic [ADDR_W-1:0] rd_idx;
    rvga_word          rd_data;
    logic              mem_we;
    logic              unused_addr_lsbs;

`ifdef RVGA_MEM_BYTE_EN
    assign req_be = be_i;
`else
    assign req_be = 4'hF;
`endif

    assign unused_addr_lsbs = ^addr_i[1:0];
    assign req_oor          = (addr_i[31:2] >= 30'(els_p));

    // In IDLE the live request is used so a latency of one can answer directly.
    always_comb begin
        cur_wr  = wr_q;
        cur_oor = oor_q;
        rd_idx  = idx_q;
        if (state_q == IDLE) begin
            cur_wr  = w_v_i;
            cur_oor = req_oor;
            rd_idx  = addr_i[2 +: ADDR_W];
        end
    end

    assign mem_we = (state_q == RESP) && wr_q && !oor_q;

    rvga_mem_array #(
        .els_p   (els_p)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            resp_v_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            resp_v_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (r_v_i || w_v_i) begin
                        idx_q   <= addr_i[2 +: ADDR_W];
                        wdata_q <= data_i;
                        be_q    <= req_be;
                        wr_q    <= w_v_i;
                        oor_q   <= req_oor;
                        if (latency_p == 1) begin
                            state_q  <= RESP;
                            cnt_q    <= '0;
                            resp_v_q <= 1'b1;
                            err_q    <= cur_oor;
                            data_q   <= (cur_wr || cur_oor) ? '0 : rd_data;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= RESP;
                        resp_v_q <= 1'b1;
                        err_q    <= cur_oor;
                        data_q   <= (cur_wr || cur_oor) ? '0 : rd_data;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_v_o = resp_v_q;
    assign data_o   = data_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rvga_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_rvga_mem_responder
//  Directed vector bench for rvga_mem_responder (els_p=16, latency_p=2).
//  Revision: 1.0
// ============================================================================
module tb_rvga_mem_responder;
    import rvga_types::*;

    localparam int ELS = 16;
    localparam int LAT = 2;
    localparam int NV  = 14;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       r_v_i  = 1'b0;
    logic       w_v_i  = 1'b0;
    rvga_word   addr_i = '0;
    rvga_word   data_i = '0;
    logic [3:0] be_i   = 4'hF;
    rvga_word   data_o;
    logic       resp_v_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rvga_mem_responder #(
        .els_p     (ELS),
        .latency_p (LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .r_v_i     (r_v_i),
        .w_v_i     (w_v_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
`ifdef RVGA_MEM_BYTE_EN
        .be_i      (be_i),
`endif
        .data_o    (data_o),
        .resp_v_o  (resp_v_o),
        .err_o     (err_o)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        rvga_word   addr;
        rvga_word   data;
        logic [3:0] be;
        rvga_word   exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE, scrambles the inputs after capture and
    // returns the response; leaves the DUT back in IDLE.
    task automatic access(input logic rd, input logic wr, input rvga_word a, input rvga_word d,
                          input logic [3:0] be, output rvga_word dout, output logic eout,
                          output int lat);
        r_v_i  = rd;
        w_v_i  = wr;
        addr_i = a;
        data_i = d;
        be_i   = be;
        lat    = -1;
        dout   = '0;
        eout   = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk_i); #1;
            addr_i = ~a;
            data_i = ~d;
            be_i   = ~be;
            if (resp_v_o === 1'b1) begin
                lat  = n;
                dout = data_o;
                eout = err_o;
            end
        end
        r_v_i = 1'b0;
        w_v_i = 1'b0;
        @(posedge clk_i); #1;
        check("resp_single_pulse", {31'b0, resp_v_o}, 32'h0);
        check("quiet_data", data_o, 32'h0);
        check("quiet_err", {31'b0, err_o}, 32'h0);
    endtask

    rvga_word d_got;
    logic     e_got;
    int       lat_got;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h13,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h40,       32'h0,        4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h40,       32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h00,       32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h20,       32'h5,        4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h20,       32'h0,        4'hF, 32'h5,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h3C,       32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h3E,       32'h0,        4'hF, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h24,       32'h5A0FF0A5, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h24,       32'h0,        4'hF, 32'h5A0FF0A5, 1'b0};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_resp_v", {31'b0, resp_v_o}, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < NV; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                   d_got, e_got, lat_got);
            check($sformatf("vec%0d_latency", i), lat_got, LAT);
            check($sformatf("vec%0d_data", i), d_got, vecs[i].exp_d);
            check($sformatf("vec%0d_err", i), {31'b0, e_got}, {31'b0, vecs[i].exp_e});
        end

        // Back-to-back reads with the request held: one response every LAT+1 cycles
        begin
            rvga_word tp_addr [4];
            rvga_word tp_exp  [4];
            int pulses;
            int last;
            tp_addr = '{32'h10, 32'h20, 32'h3C, 32'h00};
            tp_exp  = '{32'hDEADBEEF, 32'h5, 32'hA5A5A5A5, 32'hCAFEF00D};
            pulses  = 0;
            last    = 0;
            r_v_i   = 1'b1;
            addr_i  = tp_addr[0];
            for (int c = 1; c <= 13; c++) begin
                @(posedge clk_i); #1;
                if (resp_v_o === 1'b1) begin
                    if (pulses > 0) check("tp_interval", c - last, LAT + 1);
                    if (pulses < 4) check("tp_data", data_o, tp_exp[pulses]);
                    last = c;
                    pulses++;
                    if (pulses < 4) addr_i = tp_addr[pulses];
                    else r_v_i = 1'b0;
                end
            end
            r_v_i = 1'b0;
            check("tp_pulses", pulses, 4);
        end

        // Reset during BUSY aborts a write with no response
        begin
            int seen;
            seen   = 0;
            w_v_i  = 1'b1;
            addr_i = 32'h10;
            data_i = 32'h0BADF00D;
            @(posedge clk_i); #1;
            rst_ni = 1'b0;
            w_v_i  = 1'b0;
            #1;
            check("abort_resp_v", {31'b0, resp_v_o}, 32'h0);
            repeat (2) @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk_i); #1;
                if (resp_v_o !== 1'b0) seen++;
            end
            check("abort_no_resp", seen, 0);
            access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, d_got, e_got, lat_got);
            check("abort_word_kept", d_got, 32'hDEADBEEF);
        end

        // Reset during RESP clears outputs without waiting for an edge
        begin
            r_v_i  = 1'b1;
            addr_i = 32'h20;
            repeat (LAT) @(posedge clk_i);
            #1;
            check("resp_before_rst", {31'b0, resp_v_o}, 32'h1);
            rst_ni = 1'b0;
            r_v_i  = 1'b0;
            #1;
            check("async_rst_resp_v", {31'b0, resp_v_o}, 32'h0);
            check("async_rst_data", data_o, 32'h0);
            @(posedge clk_i); #1;
            rst_ni = 1'b1;
            @(posedge clk_i); #1;
        end

        // Byte-masked write
        begin
            rvga_word exp_word;
`ifdef RVGA_MEM_BYTE_EN
            exp_word = 32'h11BB33DD;
`else
            exp_word = 32'hAABBCCDD;
`endif
            access(1'b0, 1'b1, 32'h28, 32'h11223344, 4'hF, d_got, e_got, lat_got);
            access(1'b0, 1'b1, 32'h28, 32'hAABBCCDD, 4'b0101, d_got, e_got, lat_got);
            access(1'b1, 1'b0, 32'h28, 32'h0, 4'hF, d_got, e_got, lat_got);
            check("byte_en_word", d_got, exp_word);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
